// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - control and scan-output bundle for the 7-seg scan controller
interface display_scan_ctrl_if;
   logic       en;
   logic [3:0] blank_mask;
   logic [3:0] brightness;
   logic [1:0] SS;
   logic [3:0] an;
   logic       digit_tick;
   logic       frame_done;

   modport master (
      output en, blank_mask, brightness,
      input  SS, an, digit_tick, frame_done
   );

   modport slave (
      input  en, blank_mask, brightness,
      output SS, an, digit_tick, frame_done
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-seg scan controller with per-digit blanking and 16-level PWM
module display_scan_ctrl #(
   parameter int PRESCALE = 100000,
   parameter int CNT_W    = 17
) (
   input  logic                clk,
   input  logic                reset,
   display_scan_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] SUB_LAST  = CNT_W'(PRESCALE / 16 - 1);

   logic [CNT_W-1:0] slot_cnt, slot_n;
   logic [CNT_W-1:0] sub_cnt,  sub_n;
   logic [3:0]       phase,    phase_n;
   logic [1:0]       ss,       ss_n;
   logic [3:0]       blank_lat, blank_n;
   logic [3:0]       bright_lat, bright_n;
   logic [3:0]       an,       an_n;
   logic             digit_tick, tick_n;
   logic             frame_done, frame_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt   <= '0;
         sub_cnt    <= '0;
         phase      <= '0;
         ss         <= '0;
         an         <= 4'hf;
         digit_tick <= 1'b0;
         frame_done <= 1'b0;
         blank_lat  <= bus.blank_mask;
         bright_lat <= bus.brightness;
      end else begin
         slot_cnt   <= slot_n;
         sub_cnt    <= sub_n;
         phase      <= phase_n;
         ss         <= ss_n;
         an         <= an_n;
         digit_tick <= tick_n;
         frame_done <= frame_n;
         blank_lat  <= blank_n;
         bright_lat <= bright_n;
      end
   end

   // Settings only reload on the 3->0 wrap so a frame never mixes old and new values.
   always_comb begin
      slot_n   = slot_cnt;
      sub_n    = sub_cnt;
      phase_n  = phase;
      ss_n     = ss;
      blank_n  = blank_lat;
      bright_n = bright_lat;
      tick_n   = 1'b0;
      frame_n  = 1'b0;
      if (bus.en) begin
         if (slot_cnt == SLOT_LAST) begin
            slot_n = '0;
            sub_n  = '0;
            phase_n = '0;
            ss_n   = ss + 2'd1;
            tick_n = 1'b1;
            if (ss == 2'd3) begin
               frame_n  = 1'b1;
               blank_n  = bus.blank_mask;
               bright_n = bus.brightness;
            end
         end else begin
            slot_n = slot_cnt + 1'b1;
            if (sub_cnt == SUB_LAST) begin
               sub_n   = '0;
               phase_n = phase + 4'd1;
            end else begin
               sub_n = sub_cnt + 1'b1;
            end
         end
      end
   end

   // Anodes derive from next-state values so they switch on the same edge as SS.
   always_comb begin
      an_n = 4'hf;
      if (bus.en && !blank_n[ss_n] && (phase_n <= bright_n))
         an_n[ss_n] = 1'b0;
   end

   assign bus.SS         = ss;
   assign bus.an         = an;
   assign bus.digit_tick = digit_tick;
   assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - scoreboard bench for display_scan_ctrl against a slot/frame reference model
module tb_display_scan_ctrl;

   localparam int P = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   display_scan_ctrl_if bus();

   display_scan_ctrl #(.PRESCALE(P), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];

   logic       cur_en;
   logic [3:0] cur_bm;
   logic [3:0] cur_br;

   int         m_slot = 0;
   int         m_ss = 0;
   int         m_bright = 0;
   logic [3:0] m_blank = 4'h0;
   logic [3:0] m_an = 4'hf;
   logic       m_tick = 1'b0;
   logic       m_frame = 1'b0;

   // Reference: position within slot, digit index, on-time as a fraction of the slot.
   task automatic model_step(input logic r);
      if (r) begin
         m_slot = 0; m_ss = 0; m_an = 4'hf; m_tick = 1'b0; m_frame = 1'b0;
         m_blank = cur_bm; m_bright = int'(cur_br);
      end else begin
         m_tick = 1'b0;
         m_frame = 1'b0;
         if (cur_en) begin
            if (m_slot == P - 1) begin
               m_slot = 0;
               m_tick = 1'b1;
               if (m_ss == 3) begin
                  m_frame = 1'b1;
                  m_blank = cur_bm;
                  m_bright = int'(cur_br);
               end
               m_ss = (m_ss + 1) % 4;
            end else begin
               m_slot++;
            end
         end
         m_an = 4'hf;
         if (cur_en && !m_blank[m_ss] && (m_slot / (P / 16)) <= m_bright)
            m_an[m_ss] = 1'b0;
      end
   endtask

   task automatic drive(input logic r);
      @(negedge clk);
      reset = r;
      bus.en = cur_en;
      bus.blank_mask = cur_bm;
      bus.brightness = cur_br;
      model_step(r);
      exp_q.push_back({2'(m_ss), m_an, m_tick, m_frame});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive(1'b0);
   endtask

   task automatic run_until(input int ss, input int slot);
      for (int i = 0; i < 4 * P + 4; i++) begin
         if (m_ss == ss && m_slot == slot) break;
         drive(1'b0);
      end
   endtask

   initial begin : monitor
      logic [7:0] e;
      logic [7:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {bus.SS, bus.an, bus.digit_tick, bus.frame_done};
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL scan_out t=%0t got ss=%0d an=%b tick=%b frame=%b, expected ss=%0d an=%b tick=%b frame=%b",
                        $time, got[7:6], got[5:2], got[1], got[0], e[7:6], e[5:2], e[1], e[0]);
            end
         end
      end
   end

   initial begin : stimulus
      reset = 1'b1;
      bus.en = 1'b0;
      bus.blank_mask = 4'h0;
      bus.brightness = 4'hf;
      cur_en = 1'b1;
      cur_bm = 4'h0;
      cur_br = 4'hf;

      repeat (3) drive(1'b1);
      run(260);

      cur_br = 4'd7;
      run(300);
      cur_br = 4'd0;
      run(300);
      cur_br = 4'd15;
      run(140);

      run_until(1, 5);
      cur_bm = 4'b0100;
      run(300);
      cur_bm = 4'b0000;

      run_until(2, P - 1);
      cur_en = 1'b0;
      run(20);
      cur_en = 1'b1;
      run(80);

      run_until(2, 10);
      cur_en = 1'b0;
      run(20);
      cur_en = 1'b1;
      run(100);

      run_until(2, 15);
      cur_en = 1'b0;
      drive(1'b1);
      cur_en = 1'b1;
      run(200);

      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 63) == 0) cur_bm = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) cur_br = 4'($urandom_range(0, 15));
         cur_en = ($urandom_range(0, 15) != 0);
         drive($urandom_range(0, 999) == 0);
      end

      repeat (4) @(posedge clk);
      #2;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
